// File: rtl/frog_motion_ctrl_if.sv
// Button/control inputs and frog bounding-box outputs of the frog motion controller.
// The game side (or a bench) uses master; the controller uses slave.
interface frog_motion_ctrl_if;
  logic       buttonup;
  logic       buttondown;
  logic       buttonleft;
  logic       buttonright;
  logic       pseudo;
  logic       freeze;
  logic [9:0] frogL;
  logic [9:0] frogR;
  logic [8:0] frogT;
  logic [8:0] frogB;
  logic       hop_o;

  modport master (
    output buttonup, buttondown, buttonleft, buttonright, pseudo, freeze,
    input  frogL, frogR, frogT, frogB, hop_o
  );

  modport slave (
    input  buttonup, buttondown, buttonleft, buttonright, pseudo, freeze,
    output frogL, frogR, frogT, frogB, hop_o
  );
endinterface

// File: rtl/frog_motion_ctrl.sv
// Frog position controller: synchronise and debounce four buttons, turn each press
// into one clamped grid hop, with respawn and freeze overriding movement.
module frog_motion_ctrl #(
  parameter int DEB_CYCLES = 1000000,
  parameter int FROG_W     = 20,
  parameter int FROG_H     = 20,
  parameter int STEP_X     = 20,
  parameter int STEP_Y     = 25,
  parameter int START_L    = 310,
  parameter int START_T    = 430,
  parameter int AREA_L     = 20,
  parameter int AREA_R     = 620,
  parameter int AREA_T     = 20,
  parameter int AREA_B     = 460
) (
  input  logic               clk_in,
  input  logic               reset_in,
  frog_motion_ctrl_if.slave  bus
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  localparam logic [10:0] STEP_X11 = 11'(STEP_X);
  localparam logic [10:0] STEP_Y11 = 11'(STEP_Y);
  localparam logic [10:0] L_MAX    = 11'(AREA_R - FROG_W + 1);
  localparam logic [10:0] T_MAX    = 11'(AREA_B - FROG_H + 1);
  // Below these thresholds a left/up hop would cross the wall, so clamp instead.
  localparam logic [10:0] LEFT_LIM = 11'(AREA_L + STEP_X);
  localparam logic [10:0] UP_LIM   = 11'(AREA_T + STEP_Y);

  logic [3:0] raw;
  logic [3:0] press;

  assign raw = {bus.buttonup, bus.buttondown, bus.buttonleft, bus.buttonright};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_btn
      logic          sync1;
      logic          sync2;
      logic          deb;
      logic          deb_d;
      logic          press_p;
      logic [CW-1:0] cnt;

      always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
          sync1   <= 1'b0;
          sync2   <= 1'b0;
          deb     <= 1'b0;
          deb_d   <= 1'b0;
          press_p <= 1'b0;
          cnt     <= '0;
        end else begin
          sync1   <= raw[gi];
          sync2   <= sync1;
          deb_d   <= deb;
          press_p <= deb & ~deb_d;
          if (sync2 == deb) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            deb <= ~deb;
            cnt <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      end

      assign press[gi] = press_p;
    end
  endgenerate

  logic [9:0]  l_reg, r_reg;
  logic [8:0]  t_reg, b_reg;
  logic        hop_reg;
  logic [10:0] l_ext, t_ext, l_sum, t_sum;
  logic [9:0]  l_next;
  logic [8:0]  t_next;
  logic        moved;

  assign l_ext = {1'b0, l_reg};
  assign t_ext = {2'b00, t_reg};
  assign l_sum = l_ext + STEP_X11;
  assign t_sum = t_ext + STEP_Y11;

  always_comb begin
    l_next = l_reg;
    t_next = t_reg;
    if (press[3]) begin
      t_next = (t_ext < UP_LIM) ? 9'(AREA_T) : 9'(t_ext - STEP_Y11);
    end else if (press[2]) begin
      t_next = (t_sum > T_MAX) ? 9'(T_MAX) : 9'(t_sum);
    end else if (press[1]) begin
      l_next = (l_ext < LEFT_LIM) ? 10'(AREA_L) : 10'(l_ext - STEP_X11);
    end else if (press[0]) begin
      l_next = (l_sum > L_MAX) ? 10'(L_MAX) : 10'(l_sum);
    end
    moved = (l_next != l_reg) || (t_next != t_reg);
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      l_reg   <= 10'(START_L);
      r_reg   <= 10'(START_L + FROG_W - 1);
      t_reg   <= 9'(START_T);
      b_reg   <= 9'(START_T + FROG_H - 1);
      hop_reg <= 1'b0;
    end else if (bus.pseudo) begin
      l_reg   <= 10'(START_L);
      r_reg   <= 10'(START_L + FROG_W - 1);
      t_reg   <= 9'(START_T);
      b_reg   <= 9'(START_T + FROG_H - 1);
      hop_reg <= 1'b0;
    end else if (bus.freeze) begin
      hop_reg <= 1'b0;
    end else begin
      // Edges stay coherent because all four are loaded from the same next values.
      l_reg   <= l_next;
      r_reg   <= l_next + 10'(FROG_W - 1);
      t_reg   <= t_next;
      b_reg   <= t_next + 9'(FROG_H - 1);
      hop_reg <= moved;
    end
  end

  assign bus.frogL = l_reg;
  assign bus.frogR = r_reg;
  assign bus.frogT = t_reg;
  assign bus.frogB = b_reg;
  assign bus.hop_o = hop_reg;

endmodule

// File: tb/tb_frog_motion_ctrl.sv
// Randomised scoreboard bench for frog_motion_ctrl with a behavioural position model.
module tb_frog_motion_ctrl;
  localparam int DEB = 4;
  localparam int LAT = DEB + 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frog_motion_ctrl_if ifc ();

  frog_motion_ctrl #(.DEB_CYCLES(DEB)) dut (
    .clk_in   (clk),
    .reset_in (rst),
    .bus      (ifc)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int at;
    int l;
    int t;
    bit hop;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   model_l = 310;
  int   model_t = 430;

  // Monitor: every falling edge is either reset, a scheduled update, or a hold cycle.
  initial begin : monitor
    exp_t e;
    int cur_l;
    int cur_t;
    cur_l = 310;
    cur_t = 430;
    forever begin
      @(negedge clk);
      if (rst) begin
        cur_l = 310;
        cur_t = 430;
        checks++;
        if (ifc.frogL != 310 || ifc.frogR != 329 || ifc.frogT != 430 || ifc.frogB != 449 || ifc.hop_o != 0) begin
          errors++;
          $display("FAIL reset_state cyc=%0d got L=%0d R=%0d T=%0d B=%0d hop=%0b want L=310 R=329 T=430 B=449 hop=0",
                   cyc, ifc.frogL, ifc.frogR, ifc.frogT, ifc.frogB, ifc.hop_o);
        end
      end else begin
        while (sb_q.size() > 0 && sb_q[0].at < cyc) begin
          e = sb_q.pop_front();
          checks++;
          errors++;
          $display("FAIL missed_update expected at cyc=%0d now cyc=%0d want L=%0d T=%0d", e.at, cyc, e.l, e.t);
        end
        if (sb_q.size() > 0 && sb_q[0].at == cyc) begin
          e = sb_q.pop_front();
          checks += 2;
          if (ifc.frogL != e.l || ifc.frogR != e.l + 19 || ifc.frogT != e.t || ifc.frogB != e.t + 19) begin
            errors++;
            $display("FAIL update_pos cyc=%0d got L=%0d R=%0d T=%0d B=%0d want L=%0d R=%0d T=%0d B=%0d",
                     cyc, ifc.frogL, ifc.frogR, ifc.frogT, ifc.frogB, e.l, e.l + 19, e.t, e.t + 19);
          end
          if (ifc.hop_o != e.hop) begin
            errors++;
            $display("FAIL update_hop cyc=%0d got hop_o=%0b want %0b", cyc, ifc.hop_o, e.hop);
          end
          cur_l = e.l;
          cur_t = e.t;
        end else begin
          checks++;
          if (ifc.frogL != cur_l || ifc.frogR != cur_l + 19 || ifc.frogT != cur_t || ifc.frogB != cur_t + 19 || ifc.hop_o != 0) begin
            errors++;
            $display("FAIL hold_state cyc=%0d got L=%0d R=%0d T=%0d B=%0d hop=%0b want L=%0d R=%0d T=%0d B=%0d hop=0",
                     cyc, ifc.frogL, ifc.frogR, ifc.frogT, ifc.frogB, ifc.hop_o, cur_l, cur_l + 19, cur_t, cur_t + 19);
          end
        end
      end
    end
  end

  // Reference rules: respawn beats freeze beats presses; up > down > left > right.
  task automatic model_step(input logic [3:0] b, input bit frz, input bit psd, output bit hop);
    int nl;
    int nt;
    nl = model_l;
    nt = model_t;
    if (psd) begin
      nl = 310;
      nt = 430;
    end else if (!frz) begin
      if (b[3])      nt = (nt - 25 < 20) ? 20 : nt - 25;
      else if (b[2]) nt = (nt + 25 > 441) ? 441 : nt + 25;
      else if (b[1]) nl = (nl - 20 < 20) ? 20 : nl - 20;
      else if (b[0]) nl = (nl + 20 > 601) ? 601 : nl + 20;
    end
    hop = !psd && !frz && (nl != model_l || nt != model_t);
    model_l = nl;
    model_t = nt;
  endtask

  task automatic drive_btn(input logic [3:0] b);
    ifc.buttonup    = b[3];
    ifc.buttondown  = b[2];
    ifc.buttonleft  = b[1];
    ifc.buttonright = b[0];
  endtask

  task automatic push_exp(input int at, input bit hop);
    exp_t e;
    e.at  = at;
    e.l   = model_l;
    e.t   = model_t;
    e.hop = hop;
    sb_q.push_back(e);
  endtask

  task automatic press(input logic [3:0] b, input int hold, input bit frz, input bit psd);
    int c;
    bit hop;
    @(posedge clk);
    #1;
    c = cyc;
    ifc.freeze = frz;
    drive_btn(b);
    model_step(b, frz, psd, hop);
    push_exp(c + LAT, hop);
    for (int k = 1; k <= hold; k++) begin
      @(posedge clk);
      #1;
      ifc.pseudo = psd && (cyc == c + LAT - 1);
    end
    drive_btn(4'b0000);
    ifc.freeze = 1'b0;
    ifc.pseudo = 1'b0;
    repeat (12) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_l = 310;
    model_t = 430;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin : stimulus
    bit hop;
    logic [3:0] b;
    int i;
    int j;
    drive_btn(4'b0000);
    ifc.pseudo = 1'b0;
    ifc.freeze = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);

    press(4'b1000, 20, 1'b0, 1'b0);   // held up: single hop to T=405
    press(4'b0001, 12, 1'b0, 1'b0);   // L=330
    do_reset();                       // from (330,405) back to start

    press(4'b1001, 12, 1'b0, 1'b0);   // up and right together: up wins

    // Bouncing left, then stable high
    @(posedge clk);
    #1;
    for (int k = 0; k < 12; k++) begin
      ifc.buttonleft = (k % 4) < 2;
      @(posedge clk);
      #1;
    end
    ifc.buttonleft = 1'b1;
    model_step(4'b0010, 1'b0, 1'b0, hop);
    push_exp(cyc + LAT, hop);
    repeat (14) @(posedge clk);
    #1;
    ifc.buttonleft = 1'b0;
    repeat (12) @(posedge clk);

    do_reset();
    for (int k = 0; k < 18; k++) press(4'b1000, 10, 1'b0, 1'b0);
    for (int k = 0; k < 17; k++) press(4'b0001, 10, 1'b0, 1'b0);

    press(4'b0100, 10, 1'b1, 1'b0);   // frozen down
    press(4'b0010, 10, 1'b0, 1'b1);   // respawn beats left

    for (int n = 0; n < 40; n++) begin
      i = $urandom_range(0, 3);
      j = $urandom_range(0, 3);
      b = 4'b0001 << i;
      if ($urandom_range(0, 9) < 3) b = b | (4'b0001 << j);
      press(b, 10, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
    end

    repeat (20) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
